// File: rtl/simd_rs_queue_alu_if.sv
// Request/result bundle for simd_rs_queue_alu: valid/ready request channel, valid/ready result channel,
// and queue occupancy. The slave side is the ALU; the master side drives requests and consumes results.
interface simd_rs_queue_alu_if #(
   parameter int LANES    = 4,
   parameter int WIDTH    = 8,
   parameter int RS_DEPTH = 4
);
   logic                           in_valid;
   logic                           in_ready;
   logic [2:0]                     in_opcode;
   logic [LANES*WIDTH-1:0]         in_a;
   logic [LANES*WIDTH-1:0]         in_b;
   logic                           out_valid;
   logic                           out_ready;
   logic [2:0]                     out_opcode;
   logic [LANES*(WIDTH+1)-1:0]     out_result;
   logic                           out_err;
   logic [$clog2(RS_DEPTH+1)-1:0]  rs_count;

   modport slave (
      input  in_valid, in_opcode, in_a, in_b, out_ready,
      output in_ready, out_valid, out_opcode, out_result, out_err, rs_count
   );

   modport master (
      output in_valid, in_opcode, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_opcode, out_result, out_err, rs_count
   );
endinterface

// File: rtl/simd_rs_queue_alu.sv
// In-order RS queue feeding a per-lane SIMD ALU and a registered result stage; result valid two edges after the request is presented.
// in_ready drops only when the queue is full; a stalled result (out_ready=0) holds the output register and backs up into the queue.
module simd_rs_queue_alu #(
   parameter int LANES    = 4,
   parameter int WIDTH    = 8,
   parameter int RS_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   simd_rs_queue_alu_if.slave   bus
);
   localparam int PW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
   localparam int CW = $clog2(RS_DEPTH + 1);
   localparam int AW = LANES * WIDTH;
   localparam int RW = LANES * (WIDTH + 1);

   typedef struct packed {
      logic [2:0]    op;
      logic [AW-1:0] a;
      logic [AW-1:0] b;
   } rs_entry_t;

   rs_entry_t        r_mem [RS_DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic             r_out_valid;
   logic [2:0]       r_out_op;
   logic [RW-1:0]    r_out_result;
   logic             r_out_err;

   logic             w_in_ready;
   logic             w_push;
   logic             w_issue;
   rs_entry_t        w_head;
   logic [RW-1:0]    w_result;
   logic             w_err;

   function automatic logic [WIDTH:0] lane_alu(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [WIDTH:0] r;
      r = '0;
      case (op)
         3'b000: r = {1'b0, a} + {1'b0, b};
         3'b001: r = {1'b0, a} - {1'b0, b};
         3'b010: r = {1'b0, a | b};
         3'b011: r = {1'b0, a & b};
         3'b100: r = {1'b0, a ^ b};
         3'b101: r = {1'b0, (a < b) ? a : b};
         3'b110: r = {1'b0, (a > b) ? a : b};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Full means full: a same-cycle issue does not reopen the slot.
   assign w_in_ready = (r_count != CW'(RS_DEPTH));
   assign w_push     = bus.in_valid && w_in_ready;
   assign w_issue    = (r_count != '0) && (!r_out_valid || bus.out_ready);
   assign w_head     = r_mem[r_head];

   always_comb begin
      w_result = '0;
      w_err    = (w_head.op == 3'b111);
      for (int i = 0; i < LANES; i++) begin
         w_result[i*(WIDTH+1) +: WIDTH+1] =
            lane_alu(w_head.op, w_head.a[i*WIDTH +: WIDTH], w_head.b[i*WIDTH +: WIDTH]);
      end
   end

   // Entry storage needs no reset; stale slots are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail] <= {bus.in_opcode, bus.in_a, bus.in_b};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PW'(1);
         end
         if (w_issue) begin
            r_head <= r_head + PW'(1);
         end
         if (w_push && !w_issue) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_issue) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid  <= 1'b0;
         r_out_op     <= '0;
         r_out_result <= '0;
         r_out_err    <= 1'b0;
      end else if (w_issue) begin
         r_out_valid  <= 1'b1;
         r_out_op     <= w_head.op;
         r_out_result <= w_result;
         r_out_err    <= w_err;
      end else if (bus.out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_opcode = r_out_op;
   assign bus.out_result = r_out_result;
   assign bus.out_err    = r_out_err;
   assign bus.rs_count   = r_count;
endmodule

// File: tb/tb_simd_rs_queue_alu.sv
// Bench for simd_rs_queue_alu (4 lanes x 8 bits, 4-deep queue): table vectors plus stall, streaming,
// illegal-opcode and mid-flight reset sequences, all results checked through an in-order scoreboard.
module tb_simd_rs_queue_alu;
   localparam int L = 4;
   localparam int W = 8;
   localparam int D = 4;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [35:0] r;
      logic        e;
   } vec_t;

   typedef struct {
      logic [2:0]  op;
      logic [35:0] r;
      logic        e;
   } sb_t;

   logic clk = 1'b0;
   logic reset;

   simd_rs_queue_alu_if #(.LANES(L), .WIDTH(W), .RS_DEPTH(D)) bus ();

   simd_rs_queue_alu #(.LANES(L), .WIDTH(W), .RS_DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial forever #5 clk = ~clk;

   sb_t         sb[$];
   int          total  = 0;
   int          bad    = 0;
   int          pops   = 0;
   int          pushes = 0;
   logic [35:0] cur_r;
   logic        cur_e;

   function automatic logic [31:0] pa(input logic [7:0] l0, input logic [7:0] l1,
                                      input logic [7:0] l2, input logic [7:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [35:0] pr(input logic [8:0] l0, input logic [8:0] l1,
                                      input logic [8:0] l2, input logic [8:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [35:0] r;
      logic [7:0]  x;
      logic [7:0]  y;
      r = '0;
      for (int i = 0; i < L; i++) begin
         x = a[i*8 +: 8];
         y = b[i*8 +: 8];
         case (op)
            3'd0: r[i*9 +: 9] = 9'(x) + 9'(y);
            3'd1: r[i*9 +: 9] = 9'(x) - 9'(y);
            3'd2: r[i*9 +: 9] = {1'b0, x | y};
            3'd3: r[i*9 +: 9] = {1'b0, x & y};
            3'd4: r[i*9 +: 9] = {1'b0, x ^ y};
            3'd5: r[i*9 +: 9] = {1'b0, (x <= y) ? x : y};
            3'd6: r[i*9 +: 9] = {1'b0, (x >= y) ? x : y};
            default: r[i*9 +: 9] = 9'd0;
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic mon();
      if (reset) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got op=%0d res=%h with nothing outstanding", bus.out_opcode, bus.out_result);
            end else begin
               sb_t e;
               e = sb.pop_front();
               pops++;
               chk("out_opcode", 64'(bus.out_opcode), 64'(e.op));
               chk("out_result", 64'(bus.out_result), 64'(e.r));
               chk("out_err",    64'(bus.out_err),    64'(e.e));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back('{bus.in_opcode, cur_r, cur_e});
            pushes++;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [35:0] r, input logic e);
      bus.in_valid  = 1'b1;
      bus.in_opcode = op;
      bus.in_a      = a;
      bus.in_b      = b;
      cur_r         = r;
      cur_e         = e;
   endtask

   task automatic drive_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      drive(op, a, b, model(op, a, b), (op == 3'd7));
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 40 && sb.size() != 0; c++) tick();
      tick();
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      vec_t        v[10];
      int          p0;
      int          q0;
      logic [35:0] held;

      v[0] = '{3'd0, pa(8'hFF, 8'h01, 8'h80, 8'h10), pa(8'h01, 8'h01, 8'h80, 8'h20), pr(9'h100, 9'h002, 9'h100, 9'h030), 1'b0};
      v[1] = '{3'd1, pa(8'h05, 8'h07, 8'h00, 8'hFF), pa(8'h07, 8'h05, 8'h01, 8'hFF), pr(9'h1FE, 9'h002, 9'h1FF, 9'h000), 1'b0};
      v[2] = '{3'd5, pa(8'h03, 8'h09, 8'h80, 8'h00), pa(8'h09, 8'h03, 8'h7F, 8'h00), pr(9'h003, 9'h003, 9'h07F, 9'h000), 1'b0};
      v[3] = '{3'd6, pa(8'h03, 8'h09, 8'h80, 8'h00), pa(8'h09, 8'h03, 8'h7F, 8'h00), pr(9'h009, 9'h009, 9'h080, 9'h000), 1'b0};
      v[4] = '{3'd2, pa(8'hF0, 8'h0F, 8'hAA, 8'h00), pa(8'h0F, 8'h0F, 8'h55, 8'h00), pr(9'h0FF, 9'h00F, 9'h0FF, 9'h000), 1'b0};
      v[5] = '{3'd3, pa(8'hF0, 8'h0F, 8'hAA, 8'h00), pa(8'h0F, 8'h0F, 8'h55, 8'h00), pr(9'h000, 9'h00F, 9'h000, 9'h000), 1'b0};
      v[6] = '{3'd4, pa(8'hF0, 8'h0F, 8'hAA, 8'h00), pa(8'h0F, 8'h0F, 8'h55, 8'h00), pr(9'h0FF, 9'h000, 9'h0FF, 9'h000), 1'b0};
      v[7] = '{3'd0, pa(8'h00, 8'h7F, 8'hFF, 8'hFF), pa(8'h00, 8'h01, 8'hFF, 8'h00), pr(9'h000, 9'h080, 9'h1FE, 9'h0FF), 1'b0};
      v[8] = '{3'd7, pa(8'h12, 8'h34, 8'h56, 8'h78), pa(8'h9A, 8'hBC, 8'hDE, 8'hF0), pr(9'h000, 9'h000, 9'h000, 9'h000), 1'b1};
      v[9] = '{3'd1, pa(8'h80, 8'h00, 8'h10, 8'hFE), pa(8'h7F, 8'h00, 8'h20, 8'hFF), pr(9'h001, 9'h000, 9'h1F0, 9'h1FF), 1'b0};

      // Reset held two cycles with a request pending; it must not be taken.
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      drive(3'd0, 32'h01010101, 32'h01010101, '0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      idle();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_rs_count",  64'(bus.rs_count),  64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst_out_result", 64'(bus.out_result), 64'd0);
      tick();
      tick();
      tick();
      chk("rst_nothing_queued", 64'(bus.out_valid), 64'd0);

      // Single requests: no bypass, result after the second edge.
      for (int i = 0; i < 10; i++) begin
         drive(v[i].op, v[i].a, v[i].b, v[i].r, v[i].e);
         tick();
         idle();
         chk("lat_edge1_valid", 64'(bus.out_valid), 64'd0);
         chk("lat_edge1_count", 64'(bus.rs_count),  64'd1);
         tick();
         chk("lat_edge2_valid", 64'(bus.out_valid), 64'd1);
      end
      drain();

      // Stalled output: six offered, five fit (four queued plus the output register).
      bus.out_ready = 1'b0;
      p0 = pushes;
      for (int k = 0; k < 6; k++) begin
         drive_m(3'(k), $urandom, $urandom);
         tick();
      end
      idle();
      chk("stall_accepted", 64'(pushes - p0), 64'd5);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_rs_count", 64'(bus.rs_count), 64'd4);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      held = bus.out_result;
      tick();
      tick();
      chk("stall_result_stable", 64'(bus.out_result), 64'(held));
      bus.out_ready = 1'b1;
      q0 = pops;
      drain();
      chk("stall_results_out", 64'(pops - q0), 64'd5);
      chk("stall_count_zero", 64'(bus.rs_count), 64'd0);
      chk("stall_valid_zero", 64'(bus.out_valid), 64'd0);

      // Steady state at occupancy 2: one in, one out every cycle.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_m(3'd0, $urandom, $urandom);
         tick();
      end
      idle();
      chk("steady_fill", 64'(bus.rs_count), 64'd2);
      bus.out_ready = 1'b1;
      q0 = pops;
      for (int k = 0; k < 10; k++) begin
         drive_m(3'($urandom_range(0, 7)), $urandom, $urandom);
         tick();
         chk("steady_count", 64'(bus.rs_count),  64'd2);
         chk("steady_valid", 64'(bus.out_valid), 64'd1);
      end
      idle();
      chk("steady_rate", 64'(pops - q0), 64'd10);
      drain();

      // Illegal opcode sandwiched between two ADDs, back to back.
      drive(v[0].op, v[0].a, v[0].b, v[0].r, v[0].e);
      tick();
      drive(v[8].op, v[8].a, v[8].b, v[8].r, v[8].e);
      tick();
      drive(v[7].op, v[7].a, v[7].b, v[7].r, v[7].e);
      tick();
      idle();
      drain();

      // Reset with three entries queued behind a stalled result.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_m(3'd4, $urandom, $urandom);
         tick();
      end
      idle();
      chk("midrst_pre_count", 64'(bus.rs_count), 64'd3);
      reset = 1'b1;
      tick();
      chk("midrst_count",  64'(bus.rs_count),   64'd0);
      chk("midrst_valid",  64'(bus.out_valid),  64'd0);
      chk("midrst_result", 64'(bus.out_result), 64'd0);
      chk("midrst_err",    64'(bus.out_err),    64'd0);
      chk("midrst_opcode", 64'(bus.out_opcode), 64'd0);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      chk("midrst_no_stale", 64'(bus.out_valid), 64'd0);
      chk("sb_left", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
